icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: INDEX_BITS, default 4, log2 of line count (16 lines, one 32-bit word per line).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 rdy  input  1  global ready; when 0, all state and outputs SHALL hold.
REQ-005 fetch_valid  input  1  fetch request from instruction fetch, one-cycle pulse.
REQ-006 fetch_pc  input  32  word-aligned fetch address; bits [1:0] ignored.
REQ-007 flush  input  1  cancel any in-flight fetch (branch/mispredict).
REQ-008 busy  output  1  1 = request not accepted this cycle.
REQ-009 ins_out  output  32  fetched instruction word.
REQ-010 ins_valid  output  1  ins_out valid, one-cycle pulse.
REQ-011 ic_flag  output  1  miss request to memory controller.
REQ-012 ins_addr  output  32  miss address to memory controller.
REQ-013 ins  input  32  instruction word from memory controller.
REQ-014 ins_rdy  input  1  memory controller completion, one-cycle pulse.

Function
REQ-015 Address split SHALL be: index = fetch_pc[INDEX_BITS+1:2], tag = fetch_pc[31:INDEX_BITS+2].
REQ-016 State machine SHALL have two states: IDLE, MISS.
REQ-017 IDLE: busy=0; fetch_valid accepted when rdy=1 and flush=0.
REQ-018 Hit (valid[index] and tag match) SHALL give ins_valid=1 with ins_out=data[index] on the cycle after acceptance; state stays IDLE.
REQ-019 Miss SHALL, on the cycle after acceptance, drive ic_flag=1, ins_addr={fetch_pc[31:2],2'b00}, enter MISS.
REQ-020 MISS: busy=1; ic_flag and ins_addr SHALL hold constant until ins_rdy sampled 1.
REQ-021 On ins_rdy=1 in MISS: write ins into data[index], tag, set valid; drop ic_flag next cycle; return to IDLE.
REQ-022 Miss response SHALL appear as ins_valid=1, ins_out=ins on the cycle after ins_rdy, unless cancelled (REQ-024).
REQ-023 Miss latency SHALL be memory latency + 2 cycles (accept->ic_flag, ins_rdy->ins_valid).
REQ-024 flush in MISS SHALL mark the fetch cancelled: ic_flag kept until ins_rdy (controller cannot abort), line still filled, ins_valid NOT asserted.
REQ-025 flush in IDLE SHALL suppress any ins_valid due next cycle and drop a fetch_valid presented the same cycle.
REQ-026 fetch_valid while busy=1 SHALL be ignored; upstream re-presents it.
REQ-027 ins_rdy while IDLE SHALL be ignored.
REQ-028 ins_valid SHALL never be 1 for two consecutive cycles from one request.
REQ-029 Refill to an index SHALL overwrite the old line unconditionally (direct-mapped).

Reset
REQ-030 rst=0 SHALL asynchronously force: state=IDLE, all valid bits=0, cancelled=0, busy=0, ins_valid=0, ins_out=0, ic_flag=0, ins_addr=0.
REQ-031 Reset mid-MISS SHALL abandon the miss without filling; a later ins_rdy is ignored.
REQ-032 Tag/data arrays need no reset.

Structure
REQ-033 Shared package SHALL hold: INDEX_BITS default, TAG_BITS derivation, state encoding (IDLE=0, MISS=1).
REQ-034 Storage SHALL be one sub-module, icache_array: valid/tag/data, one combinational read port, one synchronous write port, async valid clear.
REQ-035 Controller FSM, cancel flag and output registers SHALL live in icache.

Verification
REQ-036 Cold miss: reset, fetch 0x00000010 -> ic_flag=1, ins_addr=0x00000010; ins_rdy with ins=0x00500093 after 4 cycles -> ins_valid with 0x00500093 next cycle.
REQ-037 Hit: re-fetch 0x00000010 -> ins_valid, ins_out=0x00500093 next cycle, ic_flag stays 0.
REQ-038 Conflict: fetch 0x00000050 (same index 4, new tag) -> miss; then 0x00000010 -> miss again.
REQ-039 Flush in MISS: flush one cycle after ic_flag rises -> no ins_valid on ins_rdy; subsequent fetch of same address hits.
REQ-040 Stall/reset: rdy=0 for 3 cycles during MISS -> all outputs frozen; rst=0 mid-MISS -> ic_flag=0 immediately, later fetch of same address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned INDEX_BITS_DEF = 4;

  // Tag width left over from a 32-bit word address once index and byte offset are removed.
  function automatic int unsigned tag_bits(input int unsigned index_bits);
    return 32 - index_bits - 2;
  endfunction

  localparam int unsigned TAG_BITS_DEF = tag_bits(INDEX_BITS_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_e;

endpackage

// File: rtl/icache_array.sv
// Line storage: valid/tag/data with one combinational read port and one synchronous write port.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
  parameter int unsigned TAG_BITS   = tag_bits(INDEX_BITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [31:0]           rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [31:0]           wr_data_i
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  // Valid bits: cleared asynchronously, set when a line is filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data fill; these arrays carry no reset since valid gates their use.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Combinational lookup.
  always_comb begin
    rd_valid_o = valid_q[rd_idx_i];
    rd_tag_o   = tag_q[rd_idx_i];
    rd_data_o  = data_q[rd_idx_i];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache controller: hit/miss FSM, fetch cancellation and output registers.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] ins_out,
  output logic        ins_valid,
  output logic        ic_flag,
  output logic [31:0] ins_addr,
  input  logic [31:0] ins,
  input  logic        ins_rdy
);

  localparam int unsigned TAG_BITS = tag_bits(INDEX_BITS);

  state_e      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic        ins_valid_q, ins_valid_d;
  logic [31:0] ins_out_q, ins_out_d;
  logic        ic_flag_q, ic_flag_d;
  logic [31:0] ins_addr_q, ins_addr_d;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic                  hit;
  logic                  we;

  // The refill target comes from the latched miss address, not fetch_pc,
  // so upstream may change fetch_pc freely while a miss is outstanding.
  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (fetch_pc[INDEX_BITS+1:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (we),
    .wr_idx_i   (ins_addr_q[INDEX_BITS+1:2]),
    .wr_tag_i   (ins_addr_q[31:INDEX_BITS+2]),
    .wr_data_i  (ins)
  );

  assign hit       = rd_valid && (rd_tag == fetch_pc[31:INDEX_BITS+2]);
  assign we        = rdy && (state_q == MISS) && ins_rdy;
  assign busy      = (state_q == MISS);
  assign ins_out   = ins_out_q;
  assign ins_valid = ins_valid_q;
  assign ic_flag   = ic_flag_q;
  assign ins_addr  = ins_addr_q;

  // State and output registers; everything holds while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cancel_q    <= 1'b0;
      ins_valid_q <= 1'b0;
      ins_out_q   <= '0;
      ic_flag_q   <= 1'b0;
      ins_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cancel_q    <= cancel_d;
      ins_valid_q <= ins_valid_d;
      ins_out_q   <= ins_out_d;
      ic_flag_q   <= ic_flag_d;
      ins_addr_q  <= ins_addr_d;
    end
  end

  // Next-state: accept/lookup in IDLE, wait for refill in MISS.
  always_comb begin
    state_d     = state_q;
    cancel_d    = cancel_q;
    ins_valid_d = ins_valid_q;
    ins_out_d   = ins_out_q;
    ic_flag_d   = ic_flag_q;
    ins_addr_d  = ins_addr_q;
    if (rdy) begin
      ins_valid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fetch_valid && !flush) begin
            if (hit) begin
              ins_valid_d = 1'b1;
              ins_out_d   = rd_data;
            end else begin
              ic_flag_d  = 1'b1;
              ins_addr_d = fetch_pc & ~32'h3;
              cancel_d   = 1'b0;
              state_d    = MISS;
            end
          end
        end
        MISS: begin
          if (flush) begin
            cancel_d = 1'b1;
          end
          if (ins_rdy) begin
            ic_flag_d = 1'b0;
            cancel_d  = 1'b0;
            state_d   = IDLE;
            // A flush arriving together with the completion also cancels it.
            if (!cancel_q && !flush) begin
              ins_valid_d = 1'b1;
              ins_out_d   = ins;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a queue scoreboard of expected instruction words.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        busy;
  logic [31:0] ins_out;
  logic        ins_valid;
  logic        ic_flag;
  logic [31:0] ins_addr;
  logic [31:0] ins;
  logic        ins_rdy;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic [31:0] exp_q [$];
  logic [31:0] last_out;

  // Reference model of a 16-line direct-mapped cache.
  bit          mvalid [16];
  logic [25:0] mtag   [16];
  logic [31:0] mdata  [16];

  icache #(.INDEX_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .flush       (flush),
    .busy        (busy),
    .ins_out     (ins_out),
    .ins_valid   (ins_valid),
    .ic_flag     (ic_flag),
    .ins_addr    (ins_addr),
    .ins         (ins),
    .ins_rdy     (ins_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge, and score any response.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (ins_valid === 1'b1) begin
      check("ins_valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ins_out_data", ins_out, e);
      end
    end
  endtask

  task automatic clear_model();
    for (int unsigned i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] mem, input int unsigned lat,
                          input bit flush_first, input bit stall, input bit poke);
    int unsigned idx;
    logic [25:0] tg;
    bit          hit;
    bit          cancelled;
    idx = 32'(pc[5:2]);
    tg  = pc[31:6];
    hit = mvalid[idx] && (mtag[idx] == tg);
    cancelled = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    if (hit) begin
      exp_q.push_back(mdata[idx]);
      last_out = mdata[idx];
    end
    tick();
    fetch_valid = 1'b0;
    check("ic_flag_after_accept", {31'd0, ic_flag}, {31'd0, !hit});
    check("ins_valid_after_accept", {31'd0, ins_valid}, {31'd0, hit});
    if (!hit) begin
      check("ins_addr_miss", ins_addr, pc & ~32'h3);
      check("busy_in_miss", {31'd0, busy}, 32'd1);
      for (int unsigned i = 0; i < lat; i++) begin
        if (flush_first && i == 0) begin
          flush = 1'b1;
          cancelled = 1'b1;
        end
        if (poke && i == 1) begin
          fetch_valid = 1'b1;
          fetch_pc    = pc ^ 32'h0000_0040;
        end
        if (stall && i == 1) begin
          rdy = 1'b0;
          ins = 32'hFFFF_FFFF;
          repeat (3) begin
            tick();
            check("stall_ic_flag", {31'd0, ic_flag}, 32'd1);
            check("stall_ins_addr", ins_addr, pc & ~32'h3);
            check("stall_busy", {31'd0, busy}, 32'd1);
            check("stall_ins_valid", {31'd0, ins_valid}, 32'd0);
            check("stall_ins_out", ins_out, last_out);
          end
          rdy = 1'b1;
        end
        tick();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        check("miss_hold_ic_flag", {31'd0, ic_flag}, 32'd1);
        check("miss_hold_ins_addr", ins_addr, pc & ~32'h3);
        check("miss_ins_valid_low", {31'd0, ins_valid}, 32'd0);
      end
      ins_rdy = 1'b1;
      ins     = mem;
      if (!cancelled) begin
        exp_q.push_back(mem);
        last_out = mem;
      end
      tick();
      ins_rdy = 1'b0;
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      mdata[idx]  = mem;
      check("refill_ic_flag_drop", {31'd0, ic_flag}, 32'd0);
      check("refill_busy_drop", {31'd0, busy}, 32'd0);
      check("refill_ins_valid", {31'd0, ins_valid}, {31'd0, !cancelled});
    end
    tick();
    check("single_pulse", {31'd0, ins_valid}, 32'd0);
    check("ins_out_hold", ins_out, last_out);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; fetch_valid = 1'b0; fetch_pc = '0;
    flush = 1'b0; ins = '0; ins_rdy = 1'b0; last_out = '0;
    clear_model();
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_ins_out", ins_out, 32'd0);
    check("rst_ic_flag", {31'd0, ic_flag}, 32'd0);
    check("rst_ins_addr", ins_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Cold miss, then hit.
    do_fetch(32'h0000_0010, 32'h0050_0093, 4, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0000_0010, 32'h0, 0, 1'b0, 1'b0, 1'b0);

    // Conflict on index 4; a fetch presented while busy is ignored.
    do_fetch(32'h0000_0050, 32'h00A0_0113, 2, 1'b0, 1'b0, 1'b1);
    do_fetch(32'h0000_0010, 32'h0050_0093, 3, 1'b0, 1'b0, 1'b0);

    // Flush in IDLE drops a same-cycle fetch of a hit address.
    fetch_valid = 1'b1; fetch_pc = 32'h0000_0010; flush = 1'b1;
    tick();
    fetch_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ins_valid", {31'd0, ins_valid}, 32'd0);
    check("idle_flush_ic_flag", {31'd0, ic_flag}, 32'd0);
    check("idle_flush_busy", {31'd0, busy}, 32'd0);

    // Flush in MISS: fill still happens, no response; re-fetch hits.
    do_fetch(32'h0000_0024, 32'h1234_5678, 4, 1'b1, 1'b0, 1'b0);
    do_fetch(32'h0000_0024, 32'h0, 0, 1'b0, 1'b0, 1'b0);

    // Stall during miss.
    do_fetch(32'h0000_0030, 32'hCAFE_F00D, 5, 1'b0, 1'b1, 1'b0);

    // Reset mid-miss abandons the fill; a stray ins_rdy afterwards is ignored.
    fetch_valid = 1'b1; fetch_pc = 32'h0000_0040;
    tick();
    fetch_valid = 1'b0;
    check("pre_reset_ic_flag", {31'd0, ic_flag}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ic_flag", {31'd0, ic_flag}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_ins_out", ins_out, 32'd0);
    check("async_rst_ins_addr", ins_addr, 32'd0);
    clear_model();
    last_out = '0;
    tick();
    rst = 1'b1;
    ins_rdy = 1'b1; ins = 32'h0BAD_0BAD;
    tick();
    ins_rdy = 1'b0;
    check("idle_ins_rdy_ignored", {31'd0, ins_valid}, 32'd0);
    check("idle_ins_rdy_ic_flag", {31'd0, ic_flag}, 32'd0);
    do_fetch(32'h0000_0040, 32'h0000_0013, 1, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0000_0010, 32'h0050_0093, 2, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0000_0040, 32'h0, 0, 1'b0, 1'b0, 1'b0);

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
